// File: rtl/parity_frame_rx.sv
// Parity-protected byte link receiver: de-serialises LSB-first data plus a trailing parity bit.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PAR_ODD   = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdi,
  input  logic                 sdi_valid,
  input  logic                 sof,
  output logic                 sdi_ready,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 par_err,
  output logic                 frm_abort,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic PAR_SENSE = (PAR_ODD != 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_OUT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_err_q, par_err_d;
  logic              abort_q, abort_d;
  logic              accept;

  assign sdi_ready  = (state_q != S_OUT);
  assign accept     = sdi_valid & sdi_ready;
  assign dout       = data_q;
  assign dout_valid = (state_q == S_OUT);
  assign par_err    = par_err_q;
  assign frm_abort  = abort_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    abort_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && sof) begin
          data_d[0] = sdi;
          cnt_d     = CNT_W'(1);
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          // A fresh sof mid-frame restarts capture with this bit as bit0.
          if (sof) begin
            abort_d   = 1'b1;
            data_d[0] = sdi;
            cnt_d     = CNT_W'(1);
          end else begin
            data_d[cnt_q] = sdi;
            cnt_d         = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) state_d = S_PAR;
          end
        end
      end
      S_PAR: begin
        if (accept) begin
          par_err_d = sdi ^ (^data_q) ^ PAR_SENSE;
          cnt_d     = '0;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (dout_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      abort_q   <= abort_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Counts delivered bad frames; holds at all-ones until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (dout_valid && dout_ready && par_err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed self-checking bench for parity_frame_rx: an even-parity 8-bit instance
// plus an odd-parity instance with a 2-bit error counter for saturation.
module tb_parity_frame_rx;

`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       o_rst = 1'b1;
  logic       sdi = 1'b0;
  logic       sdi_valid = 1'b0;
  logic       sof = 1'b0;
  logic       dout_ready = 1'b1;

  logic       sdi_ready, dout_valid, par_err, frm_abort;
  logic [7:0] dout, err_cnt;
  logic       o_sdi_ready, o_dout_valid, o_par_err, o_frm_abort;
  logic [7:0] o_dout;
  logic [1:0] o_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .PAR_ODD(0), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sdi(sdi), .sdi_valid(sdi_valid), .sof(sof),
    .sdi_ready(sdi_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .par_err(par_err), .frm_abort(frm_abort),
    .err_cnt(err_cnt)
  );

  parity_frame_rx #(.DATA_W(8), .PAR_ODD(1), .ERR_CNT_W(2)) u_odd (
    .clk(clk), .rst(o_rst), .sdi(sdi), .sdi_valid(sdi_valid), .sof(sof),
    .sdi_ready(o_sdi_ready), .dout(o_dout), .dout_valid(o_dout_valid),
    .dout_ready(dout_ready), .par_err(o_par_err), .frm_abort(o_frm_abort),
    .err_cnt(o_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    sdi       = b;
    sof       = s;
    sdi_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    sdi_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == 0);
    send_bit(p, 1'b0);
  endtask

  initial begin
    logic [1:0] exp_sat [4];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 8'h00);
    check("rst_par_err", par_err, 0);
    check("rst_frm_abort", frm_abort, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sdi_ready", sdi_ready, 1);

    // 1: 0xAD, correct even parity 1
    send_frame(8'hAD, 1'b1);
    check("t1_valid_early", dout_valid, 0);
    idle();
    check("t1_valid", dout_valid, 1);
    check("t1_dout", dout, 8'hAD);
    check("t1_par_err", par_err, 0);
    check("t1_sdi_ready_out", sdi_ready, 0);
    check("t1_no_abort", frm_abort, 0);
    idle();
    check("t1_valid_drop", dout_valid, 0);
    check("t1_sdi_ready_back", sdi_ready, 1);

    // 2: 0x1E with wrong parity 1
    send_frame(8'h1E, 1'b1);
    idle();
    check("t2_valid", dout_valid, 1);
    check("t2_dout", dout, 8'h1E);
    check("t2_par_err", par_err, 1);
    idle();
    check("t2_err_cnt", err_cnt, CNT_ON ? 1 : 0);

    // 3: 0xFF held by back-pressure, extra bits ignored
    dout_ready = 1'b0;
    send_frame(8'hFF, 1'b0);
    idle();
    check("t3_valid0", dout_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sdi_valid = 1'b1;
      sof       = 1'b1;
      sdi       = 1'b0;
      check("t3_hold_valid", dout_valid, 1);
      check("t3_hold_dout", dout, 8'hFF);
      check("t3_hold_par_err", par_err, 0);
      check("t3_hold_sdi_ready", sdi_ready, 0);
    end
    @(negedge clk);
    sdi_valid  = 1'b0;
    sof        = 1'b0;
    dout_ready = 1'b1;
    check("t3_valid_pre_hs", dout_valid, 1);
    check("t3_dout_pre_hs", dout, 8'hFF);
    @(negedge clk);
    check("t3_valid_post_hs", dout_valid, 0);
    check("t3_dout_kept", dout, 8'hFF);
    check("t3_sdi_ready", sdi_ready, 1);
    check("t3_no_abort", frm_abort, 0);
    check("t3_err_cnt", err_cnt, CNT_ON ? 1 : 0);

    // 4: 3 bits then restart with 0x5A, parity 0
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(logic'((8'h5A >> i) & 8'h01), i == 0);
      if (i == 0) check("t4_abort_before", frm_abort, 0);
      if (i == 1) check("t4_abort_pulse", frm_abort, 1);
      if (i == 2) check("t4_abort_end", frm_abort, 0);
    end
    send_bit(1'b0, 1'b0);
    idle();
    check("t4_valid", dout_valid, 1);
    check("t4_dout", dout, 8'h5A);
    check("t4_par_err", par_err, 0);
    check("t4_abort_quiet", frm_abort, 0);
    idle();

    // 5: reset after 5 data bits, stray bits, then 0x01 with gaps
    for (int i = 0; i < 5; i++) send_bit(logic'((8'hC3 >> i) & 8'h01), i == 0);
    @(negedge clk);
    sdi_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", dout_valid, 0);
    check("t5_rst_dout", dout, 8'h00);
    check("t5_rst_err_cnt", err_cnt, 0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    idle();
    idle();
    check("t5_gap_valid", dout_valid, 0);
    for (int i = 1; i < 8; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle();
    check("t5_valid", dout_valid, 1);
    check("t5_dout", dout, 8'h01);
    check("t5_par_err", par_err, 0);
    idle();
    check("t5_err_cnt", err_cnt, 0);

    // 6: odd parity instance, bad frames saturate a 2-bit counter
    o_rst = 1'b0;
    idle();
    check("t6_rst_err_cnt", o_err_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h00, 1'b0);
      idle();
      check("t6_valid", o_dout_valid, 1);
      check("t6_par_err", o_par_err, 1);
      idle();
      check("t6_err_cnt", o_err_cnt, CNT_ON ? exp_sat[k] : 2'd0);
    end
    send_frame(8'h00, 1'b1);
    idle();
    check("t6_good_valid", o_dout_valid, 1);
    check("t6_good_par_err", o_par_err, 0);
    idle();
    check("t6_good_err_cnt", o_err_cnt, CNT_ON ? 2'd3 : 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
